// File: rtl/cgra_job_sequencer.sv
// Job sequencer for a CGRA tile: queues DMA+compute descriptors, then runs each
// job as DMA transfer -> CU run -> completion, with a per-wait timeout.
module cgra_job_sequencer #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 65535
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      job_valid,
  output logic                      job_ready,
  input  logic [31:0]               job_src,
  input  logic [31:0]               job_dst,
  input  logic [31:0]               job_size,
  input  logic                      abort,
  input  logic                      err_clr,
  output logic [31:0]               dma_src,
  output logic [31:0]               dma_dst,
  output logic [31:0]               dma_size,
  output logic                      dma_start,
  input  logic                      dma_done_i,
  output logic                      cu_start,
  input  logic                      cu_done_i,
  output logic                      job_done,
  output logic [15:0]               jobs_completed,
  output logic [$clog2(DEPTH):0]    queue_count,
  output logic                      busy,
  output logic                      err
);
  localparam int PW = $clog2(DEPTH);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, DMA_GO, DMA_WAIT, CU_GO, CU_WAIT, COMPLETE} state_t;
  state_t state;

  logic [31:0]   q_src  [DEPTH];
  logic [31:0]   q_dst  [DEPTH];
  logic [31:0]   q_size [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [TW-1:0] tcnt;
  logic          full, push, pop;

  assign full      = (queue_count == (PW+1)'(DEPTH));
  assign job_ready = rst_n && !full && !abort;
  assign push      = job_valid && job_ready;
  assign pop       = (state == IDLE) && (queue_count != '0) && !abort;
  assign busy      = (state != IDLE) || (queue_count != '0);

  always_ff @(posedge clk) begin
    if (push) begin
      q_src[wr_ptr]  <= job_src;
      q_dst[wr_ptr]  <= job_dst;
      q_size[wr_ptr] <= job_size;
    end
  end

  // Abort drops everything by snapping the read pointer onto the write pointer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      queue_count <= '0;
    end else if (abort) begin
      rd_ptr      <= wr_ptr;
      queue_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      queue_count <= queue_count + (PW+1)'(push) - (PW+1)'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= IDLE;
      dma_src        <= '0;
      dma_dst        <= '0;
      dma_size       <= '0;
      dma_start      <= 1'b0;
      cu_start       <= 1'b0;
      job_done       <= 1'b0;
      jobs_completed <= '0;
      tcnt           <= '0;
      err            <= 1'b0;
    end else begin
      dma_start <= 1'b0;
      cu_start  <= 1'b0;
      job_done  <= 1'b0;
      // A timeout below overrides a coincident clear.
      if (err_clr) err <= 1'b0;
      if (abort) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: if (queue_count != '0) begin
            dma_src   <= q_src[rd_ptr];
            dma_dst   <= q_dst[rd_ptr];
            dma_size  <= q_size[rd_ptr];
            dma_start <= 1'b1;
            state     <= DMA_GO;
          end
          DMA_GO: begin
            tcnt  <= '0;
            state <= DMA_WAIT;
          end
          DMA_WAIT: if (dma_done_i) begin
            cu_start <= 1'b1;
            state    <= CU_GO;
          end else if (tcnt == TW'(TIMEOUT - 1)) begin
            err   <= 1'b1;
            state <= IDLE;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
          CU_GO: begin
            tcnt  <= '0;
            state <= CU_WAIT;
          end
          CU_WAIT: if (cu_done_i) begin
            job_done       <= 1'b1;
            jobs_completed <= jobs_completed + 1'b1;
            state          <= COMPLETE;
          end else if (tcnt == TW'(TIMEOUT - 1)) begin
            err   <= 1'b1;
            state <= IDLE;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
          COMPLETE: state <= IDLE;
          default:  state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_cgra_job_sequencer.sv
// Directed + randomized bench for cgra_job_sequencer against a queue-based job model.
module tb_cgra_job_sequencer;
  localparam int DEPTH = 4;
  localparam int TMO   = 16;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        job_valid = 1'b0, abort = 1'b0, err_clr = 1'b0;
  logic        dma_done_i = 1'b0, cu_done_i = 1'b0;
  logic [31:0] job_src = '0, job_dst = '0, job_size = '0;
  logic        job_ready, dma_start, cu_start, job_done, busy, err;
  logic [31:0] dma_src, dma_dst, dma_size;
  logic [15:0] jobs_completed;
  logic [2:0]  queue_count;

  cgra_job_sequencer #(.DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .job_valid(job_valid), .job_ready(job_ready),
    .job_src(job_src), .job_dst(job_dst), .job_size(job_size),
    .abort(abort), .err_clr(err_clr),
    .dma_src(dma_src), .dma_dst(dma_dst), .dma_size(dma_size),
    .dma_start(dma_start), .dma_done_i(dma_done_i),
    .cu_start(cu_start), .cu_done_i(cu_done_i), .job_done(job_done),
    .jobs_completed(jobs_completed), .queue_count(queue_count),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] s, d, z; } job_t;
  job_t        q_m[$];
  logic [15:0] exp_jc = '0;
  int          n_assert = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Move to mid-cycle of the next cycle; pulse-type inputs default low each cycle.
  task automatic nx();
    @(negedge clk);
    job_valid = 1'b0; dma_done_i = 1'b0; cu_done_i = 1'b0;
    abort = 1'b0; err_clr = 1'b0;
  endtask

  task automatic push(input logic [31:0] s, input logic [31:0] d, input logic [31:0] z);
    job_t j;
    job_valid = 1'b1; job_src = s; job_dst = d; job_size = z;
    #1;
    chk("job_ready on push", job_ready, 1);
    j.s = s; j.d = d; j.z = z;
    q_m.push_back(j);
  endtask

  task automatic push_rand();
    push($urandom, $urandom, $urandom);
  endtask

  task automatic check_start();
    job_t j;
    for (int i = 0; i < 6 && dma_start !== 1'b1; i++) nx();
    chk("dma_start", dma_start, 1);
    if (q_m.size() != 0) begin
      j = q_m.pop_front();
      chk("dma_src", dma_src, j.s);
      chk("dma_dst", dma_dst, j.d);
      chk("dma_size", dma_size, j.z);
    end
    chk("queue_count at start", queue_count, q_m.size());
  endtask

  task automatic dma_phase(input int dd, input bit pm);
    for (int w = 1; w <= dd; w++) begin
      nx();
      chk("dma_start in wait", dma_start, 0);
      chk("cu_start in dma wait", cu_start, 0);
      chk("err in dma wait", err, 0);
      if (pm && w == 1 && q_m.size() < DEPTH) push_rand();
      if (w == dd) dma_done_i = 1'b1;
    end
    nx();
    chk("cu_start", cu_start, 1);
  endtask

  task automatic cu_phase(input int cd);
    for (int w = 1; w <= cd; w++) begin
      nx();
      chk("cu_start in cu wait", cu_start, 0);
      chk("job_done early", job_done, 0);
      if (w == cd) cu_done_i = 1'b1;
    end
    nx();
    chk("job_done", job_done, 1);
    exp_jc++;
    chk("jobs_completed", jobs_completed, exp_jc);
    chk("err after job", err, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    // reset state
    nx(); nx();
    chk("rst job_ready", job_ready, 0);
    chk("rst queue_count", queue_count, 0);
    chk("rst busy", busy, 0);
    chk("rst dma_start", dma_start, 0);
    chk("rst jobs_completed", jobs_completed, 0);
    chk("rst err", err, 0);
    chk("rst dma_src", dma_src, 0);
    rst_n = 1'b1;

    // single job with exact cycle latencies
    push(32'h1000, 32'h2000, 32'd64);
    nx();
    chk("pop cycle dma_start", dma_start, 0);
    chk("queue_count after push", queue_count, 1);
    nx();
    chk("dma_start at cycle 2", dma_start, 1);
    check_start();
    dma_phase(8, 0);
    cu_phase(9);
    nx();
    chk("idle busy", busy, 0);
    chk("job_done one cycle", job_done, 0);

    // fill queue while the first job's DMA hangs
    acc = 0;
    for (int c = 0; c < 20; c++) begin
      if (dma_start === 1'b1) check_start();
      job_valid = 1'b1; job_src = $urandom; job_dst = $urandom; job_size = $urandom;
      #1;
      if (job_ready !== 1'b1) break;
      begin
        job_t j;
        j.s = job_src; j.d = job_dst; j.z = job_size;
        q_m.push_back(j);
      end
      acc++;
      nx();
    end
    chk("accepted before full", acc, DEPTH + 1);
    chk("queue_count full", queue_count, DEPTH);
    nx();
    chk("job_ready while full", job_ready, 0);
    chk("queue_count held", queue_count, DEPTH);
    dma_phase(1, 0);
    cu_phase($urandom_range(1, 4));
    while (q_m.size() != 0) begin
      check_start();
      dma_phase($urandom_range(1, 5), 0);
      cu_phase($urandom_range(1, 5));
    end
    nx();
    chk("drained busy", busy, 0);

    // done on exactly the last allowed wait cycle
    push_rand(); nx();
    check_start();
    dma_phase(TMO, 0);
    cu_phase(TMO);
    nx();

    // randomized traffic
    for (int k = 0; k < 20; k++) begin
      if (q_m.size() == 0) begin push_rand(); nx(); end
      check_start();
      dma_phase($urandom_range(1, TMO), 1'($urandom_range(0, 1)));
      cu_phase($urandom_range(1, TMO));
      nx();
      chk("busy after complete", busy, q_m.size() != 0);
    end
    while (q_m.size() != 0) begin
      check_start();
      dma_phase($urandom_range(1, TMO), 0);
      cu_phase($urandom_range(1, TMO));
    end
    nx();

    // DMA timeout sets sticky err and discards the job
    push_rand(); nx();
    check_start();
    for (int w = 1; w <= TMO; w++) begin
      nx();
      chk("err before timeout", err, 0);
      chk("busy while waiting", busy, 1);
    end
    nx();
    chk("err at timeout", err, 1);
    chk("busy after timeout", busy, 0);
    chk("job_done after timeout", job_done, 0);
    chk("count after timeout", jobs_completed, exp_jc);
    dma_done_i = 1'b1;
    nx();
    chk("stray dma_done ignored", cu_start, 0);
    push_rand(); nx();
    check_start();
    for (int w = 1; w <= TMO; w++) begin
      nx();
      if (w == TMO) err_clr = 1'b1;
    end
    nx();
    chk("err_clr vs timeout", err, 1);
    err_clr = 1'b1;
    nx();
    chk("err cleared", err, 0);

    // abort in CU_WAIT with 3 queued
    push_rand(); nx();
    check_start();
    dma_phase(3, 0);
    for (int i = 0; i < 3; i++) begin nx(); push_rand(); end
    nx();
    chk("queued before abort", queue_count, 3);
    abort = 1'b1; job_valid = 1'b1;
    #1;
    chk("job_ready during abort", job_ready, 0);
    nx();
    q_m.delete();
    chk("abort queue_count", queue_count, 0);
    chk("abort busy", busy, 0);
    chk("abort job_done", job_done, 0);
    chk("abort dma_start", dma_start, 0);
    cu_done_i = 1'b1;
    nx();
    chk("late cu_done job_done", job_done, 0);
    chk("late cu_done count", jobs_completed, exp_jc);
    nx();
    chk("post-abort dma_start", dma_start, 0);

    // completed-count wrap
    force dut.jobs_completed = 16'hFFFF;
    nx();
    release dut.jobs_completed;
    exp_jc = 16'hFFFF;
    #1;
    chk("count preset", jobs_completed, 16'hFFFF);
    push_rand(); nx();
    check_start();
    dma_phase(2, 0);
    cu_phase(2);
    nx();

    // reset mid-job discards everything
    push_rand(); nx(); push_rand(); nx();
    check_start();
    nx();
    rst_n = 1'b0;
    nx();
    chk("mid rst job_ready", job_ready, 0);
    chk("mid rst queue_count", queue_count, 0);
    chk("mid rst busy", busy, 0);
    chk("mid rst dma_src", dma_src, 0);
    rst_n = 1'b1;
    q_m.delete();
    exp_jc = '0;
    nx();
    chk("post rst job_ready", job_ready, 1);
    chk("post rst count", jobs_completed, exp_jc);
    dma_done_i = 1'b1;
    nx();
    chk("post rst cu_start", cu_start, 0);
    chk("post rst dma_start", dma_start, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/cgra_job_sequencer.md
CGRA_JOB_SEQUENCER -- requirements
Module: cgra_job_sequencer

Interface
REQ-001 Parameter DEPTH, 4, job FIFO entries; power of two, 2..16.
REQ-002 Parameter TIMEOUT, 65535, max cycles waited for any done pulse.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst_n  input  1  synchronous, active-low reset.
REQ-005 job_valid  input  1  job descriptor offered.
REQ-006 job_ready  output  1  sequencer accepts descriptor this cycle.
REQ-007 job_src / job_dst / job_size  input  32 each  descriptor fields.
REQ-008 abort  input  1  flush queue and return to IDLE.
REQ-009 err_clr  input  1  clears sticky err.
REQ-010 dma_src / dma_dst / dma_size  output  32 each  active job fields to DMA.
REQ-011 dma_start  output  1  one-cycle DMA start pulse.
REQ-012 dma_done_i  input  1  DMA completion pulse.
REQ-013 cu_start  output  1  one-cycle CU start pulse.
REQ-014 cu_done_i  input  1  CU completion pulse.
REQ-015 job_done  output  1  one-cycle pulse per completed job.
REQ-016 jobs_completed  output  16  completed-job count, wraps 0xFFFF->0.
REQ-017 queue_count  output  $clog2(DEPTH)+1  descriptors queued.
REQ-018 busy  output  1  high when state != IDLE or queue_count != 0.
REQ-019 err  output  1  sticky timeout flag.

Function
REQ-020 FIFO: job_ready = !full && !abort; descriptor pushed when job_valid && job_ready; no push when full even if popping same cycle.
REQ-021 FSM states SHALL be IDLE, DMA_GO, DMA_WAIT, CU_GO, CU_WAIT, COMPLETE.
REQ-022 IDLE: if queue non-empty and !abort, pop head into dma_src/dst/size registers, go DMA_GO; else stay.
REQ-023 DMA_GO: dma_start = 1 for exactly this cycle; go DMA_WAIT.
REQ-024 DMA_WAIT: on dma_done_i go CU_GO; dma_done_i in any other state is ignored.
REQ-025 CU_GO: cu_start = 1 for exactly this cycle; go CU_WAIT.
REQ-026 CU_WAIT: on cu_done_i go COMPLETE; cu_done_i in any other state is ignored.
REQ-027 COMPLETE: job_done = 1 for this cycle, jobs_completed += 1, go IDLE.
REQ-028 Latency: descriptor accepted in cycle N into empty queue while IDLE -> pop in N+1, dma_start high in N+2.
REQ-029 dma_src/dst/size SHALL hold stable from DMA_GO until the next pop.
REQ-030 Timeout counter clears on entry to DMA_WAIT/CU_WAIT, increments each wait cycle; at TIMEOUT cycles without done: set err, discard job (no job_done, no count), go IDLE.
REQ-031 Done pulse in the same cycle the counter reaches TIMEOUT: done wins, no error.
REQ-032 err stays set until err_clr; err_clr coincident with a new timeout leaves err = 1.
REQ-033 abort (any state): next cycle state = IDLE, queue emptied, no dma_start/cu_start/job_done that cycle; in-flight job discarded, jobs_completed unchanged.
REQ-034 Simultaneous pop (IDLE) and push: queue_count unchanged, order preserved (FIFO).
REQ-035 FIFO pointers wrap modulo DEPTH; queue_count never exceeds DEPTH.

Reset
REQ-036 On rst_n = 0 at clock edge: state IDLE, queue empty, queue_count 0, job_ready 0 during reset then 1, dma_src/dst/size 0, dma_start 0, cu_start 0, job_done 0, jobs_completed 0, err 0, busy 0.
REQ-037 Reset mid-job SHALL discard all queued and active jobs with no output pulse.

Verification
REQ-038 Push {src=0x1000,dst=0x2000,size=64} at cycle 0 -> dma_start at cycle 2 with dma_src=0x1000; dma_done_i at 10 -> cu_start at 11; cu_done_i at 20 -> job_done at 21, jobs_completed=1.
REQ-039 Push DEPTH+1 jobs back-to-back while DMA never completes -> job_ready low once queue_count=DEPTH; jobs execute in push order after dones.
REQ-040 TIMEOUT=16, withhold dma_done_i -> err=1 after 16 wait cycles, state IDLE, jobs_completed unchanged; err_clr -> err=0.
REQ-041 Done pulse exactly at timeout cycle -> no err, job proceeds to cu_start.
REQ-042 abort during CU_WAIT with 3 jobs queued -> next cycle queue_count=0, busy=0, no job_done; later cu_done_i ignored.
REQ-043 jobs_completed at 0xFFFF, complete one job -> 0x0000.
